// File: rtl/shrqby_pipe_pkg.sv
// Shared types and helpers for the SPU permute-pipe byte shifters.
package spu_perm_pkg;

    localparam int QW_W      = 128;
    localparam int BYTE_W    = 8;
    localparam int NBYTES    = 16;
    localparam int CNT_W     = 5;
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [QW_W-1:0]      data;
        logic [CNT_W-1:0]     cnt;
        logic                 zero;
        logic                 rot;
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

    // Byte 0 is the most significant byte, so a right byte shift is a plain >>.
    function automatic logic [QW_W-1:0] qw_shr_bytes(input logic [QW_W-1:0] v,
                                                     input int unsigned     n,
                                                     input logic            rot);
        logic [QW_W-1:0] sh;
        logic [QW_W-1:0] wrap;
        sh   = v >> (BYTE_W * n);
        wrap = (n == 0) ? '0 : v << (QW_W - BYTE_W * n);
        return rot ? (sh | wrap) : sh;
    endfunction

endpackage

// File: rtl/qw_byte_shr.sv
// Combinational quadword right shift by 0..3 steps of UNIT bytes, zero-fill or rotate.
module qw_byte_shr
    import spu_perm_pkg::*;
#(
    parameter int unsigned UNIT = 1
) (
    input  logic [QW_W-1:0] din,
    input  logic [1:0]      amt,
    input  logic            rot,
    output logic [QW_W-1:0] dout
);

    always_comb begin
        dout = din;
        case (amt)
            2'd0:    dout = din;
            2'd1:    dout = qw_shr_bytes(din, UNIT, rot);
            2'd2:    dout = qw_shr_bytes(din, 2 * UNIT, rot);
            default: dout = qw_shr_bytes(din, 3 * UNIT, rot);
        endcase
    end

endmodule

// File: rtl/shrqby_pipe.sv
// Three-stage quadword byte-right-shift pipe with valid/ready, tag and flush.
// Define SHRQBY_ROT_EN to enable rotate-right selected by op_rot.
module shrqby_pipe
    import spu_perm_pkg::*;
#(
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     ra,
    input  logic [0:127]     rb,
    input  logic             op_rot,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     result,
    output logic [TAG_W-1:0] out_tag
);

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    stage_t s3_q, s3_d;

    logic [QW_W-1:0]  ra_w;
    logic [CNT_W-1:0] cnt_in;
    logic             rot_in;
    logic [QW_W-1:0]  coarse_data;
    logic [QW_W-1:0]  fine_data;
    logic             s1_free, s2_free, s3_free;
    logic             unused_bits;

    assign ra_w   = ra;
    assign cnt_in = rb[27:31];

`ifdef SHRQBY_ROT_EN
    assign rot_in      = op_rot;
    assign unused_bits = ^{rb[0:26], rb[32:127], s3_q.cnt, s3_q.zero, s3_q.rot,
                           s3_q.tag[TAG_MAX_W-1:TAG_W]};
`else
    assign rot_in      = 1'b0;
    assign unused_bits = ^{rb[0:26], rb[32:127], op_rot, s3_q.cnt, s3_q.zero, s3_q.rot,
                           s3_q.tag[TAG_MAX_W-1:TAG_W]};
`endif

    // Stall chain: each stage may load when empty or when the stage after it moves.
    assign s3_free  = !s3_q.valid || out_ready;
    assign s2_free  = !s2_q.valid || s3_free;
    assign s1_free  = !s1_q.valid || s2_free;
    assign in_ready = s1_free;

    qw_byte_shr #(.UNIT(4)) u_coarse (
        .din  (s1_q.data),
        .amt  (s1_q.cnt[3:2]),
        .rot  (s1_q.rot),
        .dout (coarse_data)
    );

    qw_byte_shr #(.UNIT(1)) u_fine (
        .din  (s2_q.data),
        .amt  (s2_q.cnt[1:0]),
        .rot  (s2_q.rot),
        .dout (fine_data)
    );

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (s1_free) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.data = ra_w;
                s1_d.cnt  = cnt_in;
                s1_d.rot  = rot_in;
                s1_d.zero = cnt_in[4] && !rot_in;
                s1_d.tag  = TAG_MAX_W'(in_tag);
            end
        end
        if (s2_free) begin
            s2_d      = s1_q;
            s2_d.data = s1_q.zero ? '0 : coarse_data;
        end
        if (s3_free) begin
            s3_d      = s2_q;
            s3_d.data = fine_data;
        end
        if (flush) begin
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
            s3_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid = s3_q.valid;
    assign result    = s3_q.data;
    assign out_tag   = s3_q.tag[TAG_W-1:0];

endmodule

// File: tb/tb_shrqby_pipe.sv
// Scoreboard bench for shrqby_pipe: directed cases from the operation rules plus
// randomized traffic with random back-pressure, checked against a byte-array model.
module tb_shrqby_pipe;

    localparam int TAG_W = 7;
    localparam logic [127:0] A_QW = 128'h00112233445566778899AABBCCDDEEFF;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [0:127]     ra;
    logic [0:127]     rb;
    logic             op_rot;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [0:127]     result;
    logic [TAG_W-1:0] out_tag;

    shrqby_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra        (ra),
        .rb        (rb),
        .op_rot    (op_rot),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]     res;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               passed = 0;
    int               total = 0;
    int               cyc = 0;
    logic [127:0]     cur_exp = '0;
    bit               cur_lat = 1'b0;
    bit               rand_rdy = 1'b0;
    bit               held_v = 1'b0;
    logic [127:0]     held_res = '0;
    logic [TAG_W-1:0] held_tag = '0;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string name, input bit ok,
                               input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (ok) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: result byte b takes ra byte b-s (zero fill) or (b-s) mod 16 (rotate).
    function automatic logic [127:0] refModel(input logic [127:0] a, input int s, input bit rot);
        logic [7:0]   ib[16];
        logic [7:0]   ob[16];
        logic [127:0] r;
        for (int b = 0; b < 16; b++) ib[b] = a[127-8*b -: 8];
        for (int b = 0; b < 16; b++) begin
            if (rot) ob[b] = ib[(b - (s % 16) + 16) % 16];
            else     ob[b] = (b >= s) ? ib[b-s] : 8'h00;
        end
        r = '0;
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = ob[b];
        return r;
    endfunction

    function automatic bit effRot(input bit r);
`ifdef SHRQBY_ROT_EN
        return r;
`else
        return 1'b0 & r;
`endif
    endfunction

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: samples at negedge the handshakes that the next rising edge will perform.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checkOutput("hold_valid", out_valid, 128'(out_valid), 128'd1);
                if (out_valid) begin
                    checkOutput("hold_result", result == held_res, result, held_res);
                    checkOutput("hold_tag", out_tag == held_tag, 128'(out_tag), 128'(held_tag));
                end
            end
            held_v = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("ghost_result", 1'b0, result, 128'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("result", result == mon_e.res, result, mon_e.res);
                    checkOutput("tag", out_tag == mon_e.tag, 128'(out_tag), 128'(mon_e.tag));
                    if (mon_e.lat)
                        checkOutput("latency", (cyc - mon_e.acc) == 3,
                                    128'(cyc - mon_e.acc), 128'd3);
                end
            end else if (out_valid) begin
                held_v   = 1'b1;
                held_res = result;
                held_tag = out_tag;
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, in_tag, cyc, cur_lat});
        end
    end

    // Offer one operation and hold it until accepted; called just after a rising edge.
    task automatic applyStimulus(input logic [127:0] a, input logic [4:0] c,
                                 input logic [TAG_W-1:0] t, input bit r,
                                 input logic [127:0] exp, input bit lat);
        bit acc;
        int n;
        cur_exp  = exp;
        cur_lat  = lat;
        ra       = a;
        rb       = {$urandom, $urandom, $urandom, $urandom};
        rb[27:31] = c;
        in_tag   = t;
        op_rot   = r;
        in_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 1'b0, 128'(n), 128'd50);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] a;
        logic [4:0]   c;
        bit           r;
        int           w;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ra = '0; rb = '0; op_rot = 1'b0; in_tag = '0;
        #12;
        checkOutput("reset_out_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
        checkOutput("reset_result", result == '0, result, 128'd0);
        checkOutput("reset_out_tag", out_tag == '0, 128'(out_tag), 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 checkOutput("reset_in_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
        idle(1);

        // Directed shift counts on the reference quadword, unstalled.
        applyStimulus(A_QW, 5'd3,  7'h11, 1'b0, 128'h00000000112233445566778899AABBCC, 1'b1);
        applyStimulus(A_QW, 5'd0,  7'h22, 1'b0, A_QW, 1'b1);
        applyStimulus(A_QW, 5'd15, 7'h33, 1'b0, 128'h0, 1'b1);
        applyStimulus(A_QW, 5'd16, 7'h44, 1'b0, 128'h0, 1'b1);
        applyStimulus(A_QW, 5'd31, 7'h55, 1'b0, 128'h0, 1'b1);
        applyStimulus(A_QW, 5'd8,  7'h56, 1'b0, 128'h00000000000000000011223344556677, 1'b1);
`ifdef SHRQBY_ROT_EN
        applyStimulus(A_QW, 5'd4,  7'h66, 1'b1, 128'hCCDDEEFF00112233445566778899AABB, 1'b1);
        applyStimulus(A_QW, 5'd20, 7'h67, 1'b1, 128'hCCDDEEFF00112233445566778899AABB, 1'b1);
        applyStimulus(A_QW, 5'd16, 7'h68, 1'b1, A_QW, 1'b1);
`else
        applyStimulus(A_QW, 5'd4,  7'h66, 1'b1, 128'h0000000000112233445566778899AABB, 1'b1);
        applyStimulus(A_QW, 5'd20, 7'h67, 1'b1, 128'h0, 1'b1);
        applyStimulus(A_QW, 5'd16, 7'h68, 1'b1, 128'h0, 1'b1);
`endif
        idle(6);

        // Back-to-back stream: fixed latency on every op implies consecutive outputs.
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            c = 5'($urandom_range(0, 31));
            r = 1'($urandom_range(0, 1));
            applyStimulus(a, c, TAG_W'(i + 1), r, refModel(a, int'(c), effRot(r)), 1'b1);
        end
        idle(6);

        // Full back-pressure: three accepted, the fourth held until out_ready rises.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            c = 5'($urandom_range(0, 15));
            cur_exp = refModel(a, int'(c), 1'b0);
            cur_lat = 1'b0;
            ra = a;
            rb = '0;
            rb[27:31] = c;
            in_tag = TAG_W'(7'h40 + i);
            op_rot = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("bp_in_ready_%0d", i), in_ready == (i < 3),
                        128'(in_ready), 128'(i < 3));
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("bp_still_full", in_ready == 1'b0, 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        #1 checkOutput("bp_release_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        idle(8);
        checkOutput("bp_drained", sb.size() == 0, 128'(sb.size()), 128'd0);

        // Flush with three in flight and a concurrent offer.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(a, 5'd2, TAG_W'(7'h70 + i), 1'b0, refModel(a, 2, 1'b0), 1'b0);
        end
        ra = A_QW;
        in_tag = 7'h7F;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(8);
        checkOutput("flush_no_leftover", sb.size() == 0, 128'(sb.size()), 128'd0);

        // Asynchronous reset mid-operation clears valid and data at once.
        out_ready = 1'b0;
        applyStimulus(A_QW, 5'd1, 7'h2A, 1'b0, 128'h0, 1'b0);
        applyStimulus(A_QW, 5'd2, 7'h2B, 1'b0, 128'h0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
        checkOutput("midreset_result", result == '0, result, 128'd0);
        checkOutput("midreset_out_tag", out_tag == '0, 128'(out_tag), 128'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        #1 checkOutput("midreset_in_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
        idle(6);

        // Randomized traffic with random gaps and random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            c = 5'($urandom_range(0, 31));
            r = 1'($urandom_range(0, 1));
            applyStimulus(a, c, TAG_W'($urandom), r, refModel(a, int'(c), effRot(r)), 1'b0);
            idle($urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        idle(1);
        out_ready = 1'b1;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            idle(1);
            w++;
        end
        checkOutput("final_drain", sb.size() == 0, 128'(sb.size()), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
